// File: rtl/lo_seq_ctrl_if.sv
// Configuration handshake and I/Q sample bus of the local-oscillator sequencer.
// The slave modport is the sequencer side; master is the control/mixer side.
interface lo_seq_ctrl_if #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned LEN_W   = 8
) ();
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_fcw;
  logic [LEN_W-1:0]   cfg_len;
  logic signed [8:0]  lo_i;
  logic signed [8:0]  lo_q;
  logic               lo_valid;

  modport master (
    output cfg_valid, cfg_fcw, cfg_len,
    input  cfg_ready, lo_i, lo_q, lo_valid
  );

  modport slave (
    input  cfg_valid, cfg_fcw, cfg_len,
    output cfg_ready, lo_i, lo_q, lo_valid
  );
endinterface

// File: rtl/lo_seq_ctrl.sv
// Local-oscillator sequencer: phase accumulator plus a time-shared 16-entry sine table,
// sine read in StSin, cosine read in StCos, one registered I/Q pair every two cycles.
module lo_seq_ctrl #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned LEN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  lo_seq_ctrl_if.slave      bus,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StSin, StCos} state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic signed [8:0]  sin_hold_q, sin_hold_d;
  logic signed [8:0]  lo_i_q, lo_i_d;
  logic signed [8:0]  lo_q_q, lo_q_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               stop_seen_q, stop_seen_d;

  logic               cfg_xfer;
  logic               last_pair;
  logic [3:0]         idx;
  logic [3:0]         idx_cos;

  function automatic logic signed [8:0] sine_lut(input logic [3:0] a);
    unique case (a)
      4'd0:  return 9'sd0;
      4'd1:  return 9'sd38;
      4'd2:  return 9'sd71;
      4'd3:  return 9'sd92;
      4'd4:  return 9'sd100;
      4'd5:  return 9'sd92;
      4'd6:  return 9'sd71;
      4'd7:  return 9'sd38;
      4'd8:  return 9'sd0;
      4'd9:  return -9'sd38;
      4'd10: return -9'sd71;
      4'd11: return -9'sd92;
      4'd12: return -9'sd100;
      4'd13: return -9'sd92;
      4'd14: return -9'sd71;
      4'd15: return -9'sd38;
    endcase
  endfunction

  assign idx     = phase_q[PHASE_W-1 -: 4];
  assign idx_cos = idx + 4'd4;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    fcw_d       = fcw_q;
    len_d       = len_q;
    rem_d       = rem_q;
    sin_hold_d  = sin_hold_q;
    lo_i_d      = lo_i_q;
    lo_q_d      = lo_q_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    stop_seen_d = stop_seen_q;
    last_pair   = 1'b0;
    cfg_xfer    = bus.cfg_valid && (state_q == StIdle);

    if (cfg_xfer) begin
      fcw_d = bus.cfg_fcw;
      len_d = bus.cfg_len;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSin;
          phase_d     = '0;
          // A config accepted on the start edge already governs this run.
          rem_d       = cfg_xfer ? bus.cfg_len : len_q;
          stop_seen_d = 1'b0;
        end
      end
      StSin: begin
        sin_hold_d = sine_lut(idx);
        if (stop) stop_seen_d = 1'b1;
        state_d = StCos;
      end
      StCos: begin
        lo_i_d  = sine_lut(idx_cos);
        lo_q_d  = sin_hold_q;
        valid_d = 1'b1;
        phase_d = phase_q + fcw_q;
        if (len_q != '0) rem_d = rem_q - LEN_W'(1);
        last_pair = ((len_q != '0) && (rem_q == LEN_W'(1))) || stop || stop_seen_q;
        if (last_pair) begin
          done_d      = 1'b1;
          stop_seen_d = 1'b0;
          state_d     = StIdle;
        end else begin
          state_d = StSin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      fcw_q       <= PHASE_W'(1) << (PHASE_W - 4);
      len_q       <= '0;
      rem_q       <= '0;
      sin_hold_q  <= '0;
      lo_i_q      <= '0;
      lo_q_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      fcw_q       <= fcw_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      sin_hold_q  <= sin_hold_d;
      lo_i_q      <= lo_i_d;
      lo_q_q      <= lo_q_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign bus.cfg_ready = (state_q == StIdle);
  assign bus.lo_i      = lo_i_q;
  assign bus.lo_q      = lo_q_q;
  assign bus.lo_valid  = valid_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule
